// File: rtl/seq_mult8.sv
// seq_mult8
// ---------
// Sequential unsigned W x W shift-add multiplier with a start/done handshake.
// One product is computed per accepted request using W iteration cycles; the
// 2W-bit result is presented on a registered output together with a one-cycle
// done pulse.
// That pulse is meant to drive the parallel-load strobe of the downstream
// load/shift register directly.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   start    in   request, sampled only while idle
//   clr      in   synchronous abort back to idle (wins over start)
//   A        in   W-bit multiplicand, captured on the accepting edge
//   B        in   W-bit multiplier, captured on the accepting edge
//   busy     out  high whenever the block is not idle
//   done     out  registered one-cycle completion pulse
//   product  out  registered 2W-bit result, held until the next completion
//
// W must be at least 2.
module seq_mult8 #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [W-1:0]   mcand_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic [CW-1:0]  cnt_q;
  logic           done_q;
  logic [2*W-1:0] product_q;

  logic [W:0]     sum_d;
  logic [W-1:0]   hi_d;
  logic [W-1:0]   lo_d;

  // One shift-add step. The sum keeps its carry bit, which shifts into the
  // top of hi, while the old sum LSB drops into the top of lo. The result is
  // the (2W+1)-bit {sum, lo} value shifted right by one.
  always_comb begin
    sum_d = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    hi_d  = sum_d[W:1];
    lo_d  = {sum_d[0], lo_q[W-1:1]};
  end

  // Control and datapath. The product register is written only on the edge
  // that completes the last iteration, from the freshly computed {hi_d, lo_d}.
  // An abort therefore never exposes a partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !clr) begin
            mcand_q <= A;
            lo_q    <= B;
            hi_q    <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          done_q <= 1'b0;
          if (clr) begin
            state_q <= IDLE;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
              product_q <= {hi_d, lo_d};
              done_q    <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult8.sv
// tb_seq_mult8
// ------------
// Self-checking bench for seq_mult8 (W = 8). Expected products come from
// plain A*B arithmetic. The randomized scenario keeps a queue of products
// owed for each accepted request.
module tb_seq_mult8;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clr;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int tests;
  int fails;

  seq_mult8 #(.W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .clr     (clr),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issues one request from idle and watches it to completion.
  // - latency:    number of edges after the accepting edge at which done was
  //               first seen (-1 if it never appeared).
  // - busyCycles: number of cycles with busy high.
  // - prod:       product sampled in the done cycle.
  // The watch ends at the first idle sample and is bounded at 20 cycles.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               output int latency, output int busyCycles,
                               output logic [15:0] prod);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    latency    = -1;
    busyCycles = busy ? 1 : 0;
    prod       = 16'hxxxx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done && latency < 0) begin
        latency = k;
        prod    = product;
      end
      if (!busy) break;
      busyCycles++;
    end
  endtask

  // Holds reset and checks that every output reads zero, then releases reset.
  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    clr   = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_busy got %b want 0", busy);
    end
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_done got %b want 0", done);
    end
    tests++;
    if (product !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_product got %h want 0000", product);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs 13*11 and checks latency, result and busy occupancy.
  task automatic test_basic();
    int lat;
    int bc;
    logic [15:0] p;
    applyStimulus(8'd13, 8'd11, lat, bc, p);
    tests++;
    if (lat !== 8) begin
      fails++;
      $display("[TB] FAIL basic_latency got %0d want 8", lat);
    end
    tests++;
    if (p !== 16'd143) begin
      fails++;
      $display("[TB] FAIL basic_product got %h want 008f", p);
    end
    tests++;
    if (bc !== 9) begin
      fails++;
      $display("[TB] FAIL basic_busy_cycles got %0d want 9", bc);
    end
  endtask

  // Boundary operands: full-scale, zero and a single high bit.
  task automatic test_corners();
    logic [7:0] as [3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] bs [3] = '{8'd255, 8'd200, 8'd128};
    int lat;
    int bc;
    logic [15:0] p;
    logic [15:0] expv;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(as[i], bs[i], lat, bc, p);
      expv = 16'(int'(as[i]) * int'(bs[i]));
      tests++;
      if (p !== expv) begin
        fails++;
        $display("[TB] FAIL corner_product a=%0d b=%0d got %h want %h",
                 as[i], bs[i], p, expv);
      end
      tests++;
      if (lat !== 8) begin
        fails++;
        $display("[TB] FAIL corner_latency a=%0d b=%0d got %0d want 8",
                 as[i], bs[i], lat);
      end
    end
  endtask

  // Holds start high with 3*5 presented whenever the block can accept.
  // Operands are scrambled during the calculation, which must not disturb
  // the in-flight product. Completions must be exactly 10 cycles apart.
  task automatic test_back_to_back();
    int lastDone;
    int nDone;
    A        = 8'd3;
    B        = 8'd5;
    start    = 1'b1;
    lastDone = -1;
    nDone    = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nDone++;
        tests++;
        if (product !== 16'd15) begin
          fails++;
          $display("[TB] FAIL b2b_product got %h want 000f", product);
        end
        if (lastDone >= 0) begin
          tests++;
          if (cyc - lastDone !== 10) begin
            fails++;
            $display("[TB] FAIL b2b_interval got %0d want 10", cyc - lastDone);
          end
        end
        lastDone = cyc;
        A = 8'd3;
        B = 8'd5;
      end else if (busy) begin
        A = 8'($urandom_range(0, 255));
        B = 8'($urandom_range(0, 255));
      end
    end
    start = 1'b0;
    A     = 8'd3;
    B     = 8'd5;
    tests++;
    if (nDone < 4) begin
      fails++;
      $display("[TB] FAIL b2b_done_count got %0d want >=4", nDone);
    end
    // Drain whatever is still in flight.
    for (int k = 0; k < 15 && busy; k++) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_drain busy got %b want 0", busy);
    end
  endtask

  // Aborts a 7*9 calculation in its 4th cycle. The block must drop to idle
  // without a done pulse and keep the previous product (6*7).
  task automatic test_clear();
    int lat;
    int bc;
    logic [15:0] p;
    logic sawDone;
    applyStimulus(8'd6, 8'd7, lat, bc, p);
    tests++;
    if (p !== 16'd42) begin
      fails++;
      $display("[TB] FAIL clear_setup_product got %h want 002a", p);
    end
    A     = 8'd7;
    B     = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // After the accepting edge the block is in its first calculation cycle.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clear_busy got %b want 0", busy);
    end
    sawDone = done;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
    end
    tests++;
    if (sawDone !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clear_no_done got %b want 0", sawDone);
    end
    tests++;
    if (product !== 16'd42) begin
      fails++;
      $display("[TB] FAIL clear_product_kept got %h want 002a", product);
    end
  endtask

  // Asynchronous reset in the middle of a calculation must zero the outputs
  // before any clock edge. A fresh request afterwards must still work.
  task automatic test_async_reset();
    int lat;
    int bc;
    logic [15:0] p;
    A     = 8'd100;
    B     = 8'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL async_reset got busy=%b done=%b product=%h want 0/0/0000",
               busy, done, product);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(8'd2, 8'd3, lat, bc, p);
    tests++;
    if (p !== 16'd6) begin
      fails++;
      $display("[TB] FAIL async_reset_after got %h want 0006", p);
    end
  endtask

  // Random operands and random start activity. Each sample decides, from
  // busy alone, whether the coming edge accepts the presented operands. If
  // so, A*B joins the queue of owed results. Every done pops and compares.
  task automatic test_random();
    logic [15:0] owed[$];
    int accepted;
    int completed;
    logic [15:0] expv;
    accepted  = 0;
    completed = 0;
    for (int cyc = 0; cyc < 340; cyc++) begin
      if (done) begin
        completed++;
        tests++;
        if (owed.size() == 0) begin
          fails++;
          $display("[TB] FAIL random_spurious_done product=%h", product);
        end else begin
          expv = owed.pop_front();
          if (product !== expv) begin
            fails++;
            $display("[TB] FAIL random_product got %h want %h", product, expv);
          end
        end
      end
      A     = 8'($urandom_range(0, 255));
      B     = 8'($urandom_range(0, 255));
      start = (cyc < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
      if (!busy && start) begin
        owed.push_back(16'(int'(A) * int'(B)));
        accepted++;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    tests++;
    if (completed !== accepted || owed.size() != 0) begin
      fails++;
      $display("[TB] FAIL random_done_count got %0d want %0d", completed, accepted);
    end
  endtask

  // Main sequence.
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_mult8.md
# seq_mult8

Sequential 8x8 unsigned shift-add multiplier with a start/done handshake. It sits directly upstream of the 16-bit load/shift register stage. It computes one product per request in 8 iteration cycles and presents the 16-bit result with a one-cycle `done` pulse. That pulse is the parallel-load strobe for the downstream register, which then serialises the product.

## Interface
- `W`, default 8: operand width. The product is 2W bits. The counter is clog2(W) bits wide.
- `clk` input, 1 bit: clock, rising-edge active.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: request. Sampled only in IDLE.
- `clr` input, 1 bit: synchronous abort. Returns the block to IDLE.
- `A` input, W bits: multiplicand. Captured on the accepting edge.
- `B` input, W bits: multiplier. Captured on the accepting edge.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `done` output, 1 bit: registered, high for exactly one cycle per completed product.
- `product` output, 2W bits: registered result. Held until the next completion.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: performs W iterations.
  - DONE: one cycle with `done`=1.
- Internal registers:
  - `mcand` (W bits): captured A.
  - `hi` (W bits): partial-sum upper half.
  - `lo` (W bits): multiplier / product lower half.
  - `cnt`: iteration counter.
- IDLE with `start`=1 and `clr`=0, at a rising edge:
  - `mcand` <= A, `lo` <= B, `hi` <= 0, `cnt` <= 0.
  - Next state is CALC.
- CALC, one iteration per clock:
  - `sum` = {1'b0, `hi`} + (`lo`[0] ? {1'b0, `mcand`} : 0). This is W+1 bits and never truncated.
  - {`hi`, `lo`} <= {`sum`, `lo`[W-1:1]}, i.e. a right shift of the (2W+1)-bit concatenation.
  - `cnt` <= `cnt` + 1.
- CALC exit: on the edge where `cnt` == W-1 (last iteration):
  - `product` <= the post-iteration {`hi`, `lo`} value, not the stale one.
  - Next state is DONE.
- DONE: `done`=1. Goes to IDLE unconditionally on the next edge.
- `start` handling: ignored in CALC and DONE, never queued. A request is accepted no earlier than the first edge sampled in IDLE.
- `clr` in CALC or DONE: next state IDLE. `product` and `done` are unchanged except that `done` deasserts. No partial result is ever written to `product`.
- `clr` in IDLE: no effect, and it blocks `start` in that cycle (`clr` has priority over `start`).
- Result width: unsigned only. Maximum product is (2^W - 1)^2, which always fits in 2W bits. No overflow is possible.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `product`=0.
  - `mcand`, `hi`, `lo`, `cnt` = 0.
- Asynchronous reset mid-operation: the block aborts immediately to the reset values above. No `done` is produced.
- Latency:
  - Accepting edge E0. Iteration edges E1..EW.
  - `product` updates and `done` rises after EW. `done` falls after EW+1.
  - For W=8: `done` is high in the 8th cycle after acceptance. Start-to-done is 8 cycles; total occupancy is 9 cycles.
- `busy`: rises after E0 and falls after EW+1.
- Throughput: next acceptance at EW+2 at the earliest, which gives one product per W+2 cycles with `start` held high.
- Downstream contract:
  - `product` is stable during the whole `done` cycle and afterwards, so `done` can directly drive the downstream load input.
  - `product` changes only at completion edges and reset.

## Test plan
- Reset, then A=13, B=11, `start` for 1 cycle:
  - `done` is high exactly 8 cycles after the accepting edge.
  - `product`=143 (0x008F).
  - `busy` is high for 9 cycles.
- A=255, B=255 gives `product`=0xFE01. A=0, B=200 gives 0x0000. A=1, B=128 gives 0x0080.
- Hold `start`=1 continuously with A=3, B=5: products complete every 10 cycles. A/B changes during CALC do not affect the in-flight result.
- Assert `clr` at the 4th CALC cycle with A=7, B=9:
  - Block returns to IDLE and `busy`=0 next cycle.
  - No `done`; the previous `product` is retained.
- Assert `rst` asynchronously mid-CALC: all outputs read 0 immediately. A new request afterwards (A=2, B=3) yields 6.
- Randomised back-to-back unsigned operands compared against a reference A*B: `done` count equals the number of accepted requests.
